// File: rtl/bnn_pkg.sv
// bnn_pkg: shared definitions for the BNN frame sequencer and the layer engines.
// Holds the sequencer state encoding and the image geometry.
package bnn_pkg;

    localparam int IMG_DIM = 28;
    localparam int N_PIX   = IMG_DIM * IMG_DIM;

    // Sequencer state codes, broadcast to every layer engine.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        LAYER_1 = 3'd2,
        LAYER_2 = 3'd3,
        LAYER_3 = 3'd4
    } state_t;

endpackage

// File: rtl/bnn_pixel_loader.sv
// bnn_pixel_loader: row-major serial pixel capture into the 28x28 image buffer.
// Owns the row/col counters; flags the transfer that writes the final pixel.
import bnn_pkg::*;

module bnn_pixel_loader (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              wr_en,
    input  logic                              pix_data,
    output logic [IMG_DIM-1:0][IMG_DIM-1:0]   pixels,
    output logic                              last
);

    localparam logic [4:0] LAST_IDX = 5'(IMG_DIM - 1);

    logic [4:0]                        row_r;
    logic [4:0]                        col_r;
    logic [IMG_DIM-1:0][IMG_DIM-1:0]   pixels_r;

    // Row/col position of the next transfer; col wraps into row, row wraps to 0 after the image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_r <= 5'd0;
            col_r <= 5'd0;
        end else if (clr) begin
            row_r <= 5'd0;
            col_r <= 5'd0;
        end else if (wr_en) begin
            if (col_r == LAST_IDX) begin
                col_r <= 5'd0;
                if (row_r == LAST_IDX) begin
                    row_r <= 5'd0;
                end else begin
                    row_r <= row_r + 5'd1;
                end
            end else begin
                col_r <= col_r + 5'd1;
            end
        end
    end

    // Image buffer: one bit written per accepted transfer, otherwise held stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixels_r <= '0;
        end else if (wr_en) begin
            pixels_r[row_r][col_r] <= pix_data;
        end
    end

    assign pixels = pixels_r;
    assign last   = wr_en && (row_r == LAST_IDX) && (col_r == LAST_IDX);

endmodule

// File: rtl/bnn_sequencer.sv
// bnn_sequencer: frame-level control for a three-layer binarized network.
// IDLE -> LOAD (784 serial pixels) -> LAYER_1 -> LAYER_2 -> LAYER_3 -> IDLE.
// Optional per-layer watchdog enabled by defining BNN_SEQ_TIMEOUT_EN.
import bnn_pkg::*;

module bnn_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              pix_valid,
    input  logic                              pix_data,
    output logic                              pix_ready,
    input  logic                              l1_done,
    input  logic                              l2_done,
    input  logic                              l3_done,
    output logic [2:0]                        state,
    output logic [IMG_DIM-1:0][IMG_DIM-1:0]   pixels,
    output logic                              layer_clr,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              err
);

    // The watchdog compares against TIMEOUT_CYCLES-1, so one cycle is too short to be meaningful.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("bnn_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    state_t state_r;
    state_t state_nxt_s;
    logic   first_r;        // first cycle in the current state
    logic   pix_ready_r;
    logic   busy_r;
    logic   layer_clr_r;
    logic   frame_done_r;
    logic   start_acc_s;
    logic   wr_en_s;
    logic   last_s;
    logic   layer_done_s;
    logic   adv_s;
    logic   timeout_s;

    assign start_acc_s = (state_r == IDLE) && start;
    assign wr_en_s     = pix_valid && pix_ready_r;

    bnn_pixel_loader u_loader (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_acc_s),
        .wr_en    (wr_en_s),
        .pix_data (pix_data),
        .pixels   (pixels),
        .last     (last_s)
    );

    // Select the done flag owned by the current layer; flags of other layers are ignored.
    always_comb begin
        layer_done_s = 1'b0;
        case (state_r)
            LAYER_1: layer_done_s = l1_done;
            LAYER_2: layer_done_s = l2_done;
            LAYER_3: layer_done_s = l3_done;
            default: layer_done_s = 1'b0;
        endcase
    end

    // A done flag seen in the entry cycle may be stale from the previous frame.
    assign adv_s = layer_done_s && !first_r;

`ifdef BNN_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wd_cnt_r;
    logic            in_layer_s;
    logic            err_r;

    assign in_layer_s = (state_r == LAYER_1) || (state_r == LAYER_2) || (state_r == LAYER_3);
    assign timeout_s  = in_layer_s && (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in the current layer: zero on entry, +1 per layer cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= '0;
        end else if (state_nxt_s != state_r) begin
            wd_cnt_r <= '0;
        end else if (in_layer_s) begin
            wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky error: set by a watchdog abort, cleared when the next frame is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (start_acc_s) begin
            err_r <= 1'b0;
        end else if (timeout_s && !adv_s) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state selection; a layer done takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = LOAD;
                else       state_nxt_s = IDLE;
            end
            LOAD: begin
                if (last_s) state_nxt_s = LAYER_1;
                else        state_nxt_s = LOAD;
            end
            LAYER_1: begin
                if (adv_s)          state_nxt_s = LAYER_2;
                else if (timeout_s) state_nxt_s = IDLE;
                else                state_nxt_s = LAYER_1;
            end
            LAYER_2: begin
                if (adv_s)          state_nxt_s = LAYER_3;
                else if (timeout_s) state_nxt_s = IDLE;
                else                state_nxt_s = LAYER_2;
            end
            LAYER_3: begin
                if (adv_s)          state_nxt_s = IDLE;
                else if (timeout_s) state_nxt_s = IDLE;
                else                state_nxt_s = LAYER_3;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            first_r      <= 1'b0;
            pix_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            layer_clr_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            first_r      <= (state_nxt_s != state_r);
            pix_ready_r  <= (state_nxt_s == LOAD);
            busy_r       <= (state_nxt_s != IDLE);
            layer_clr_r  <= start_acc_s;
            frame_done_r <= (state_r == LAYER_3) && adv_s;
        end
    end

    assign state      = state_r;
    assign pix_ready  = pix_ready_r;
    assign busy       = busy_r;
    assign layer_clr  = layer_clr_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_bnn_sequencer.sv
// tb_bnn_sequencer: directed self-checking bench for bnn_sequencer.
// Define BNN_SEQ_TIMEOUT_EN at compile time to exercise the watchdog (TIMEOUT_CYCLES=16).
import bnn_pkg::*;

module tb_bnn_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic pix_valid;
    logic pix_data;
    logic pix_ready;
    logic l1_done;
    logic l2_done;
    logic l3_done;
    logic [2:0] state;
    logic [IMG_DIM-1:0][IMG_DIM-1:0] pixels;
    logic layer_clr;
    logic busy;
    logic frame_done;
    logic err;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;

    bnn_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .l1_done    (l1_done),
        .l2_done    (l2_done),
        .l3_done    (l3_done),
        .state      (state),
        .pixels     (pixels),
        .layer_clr  (layer_clr),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Count frame_done pulses away from the active edge.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n pixels of a checkerboard (bit = r^c, optionally inverted), one per cycle.
    task automatic load_frame(input int n, input logic inv);
        for (int k = 0; k < n; k++) begin
            int r;
            int c;
            r = k / 28;
            c = k % 28;
            pix_valid = 1'b1;
            pix_data  = (r[0] ^ c[0]) ^ inv;
            if (k == 783) check_eq("pre_last_state", 32'(state), 32'd1);
            tick();
        end
        pix_valid = 1'b0;
        pix_data  = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 1'b0;
        l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
        #12;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(pix_ready), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_clr", 32'(layer_clr), 32'd0);
        check_eq("rst_fdone", 32'(frame_done), 32'd0);
        check_eq("rst_pix0", 32'(pixels[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Start held 3 cycles, with pix_valid on the accepting cycle: one LOAD entry, no pixel.
        start = 1'b1; pix_valid = 1'b1; pix_data = 1'b1;
        tick();
        check_eq("start_state", 32'(state), 32'd1);
        check_eq("start_clr", 32'(layer_clr), 32'd1);
        check_eq("start_ready", 32'(pix_ready), 32'd1);
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_nopix", 32'(pixels[0]), 32'd0);
        pix_valid = 1'b0; pix_data = 1'b0;
        tick();
        check_eq("start_hold1_state", 32'(state), 32'd1);
        check_eq("start_hold1_clr", 32'(layer_clr), 32'd0);
        tick();
        check_eq("start_hold2_clr", 32'(layer_clr), 32'd0);
        start = 1'b0;

        // Stale l1_done held high across the load and into LAYER_1.
        l1_done = 1'b1;
        load_frame(784, 1'b0);
        check_eq("load_to_l1", 32'(state), 32'd2);
        check_eq("load_row0", 32'(pixels[0]), 32'h0AAAAAAA);
        check_eq("load_row1", 32'(pixels[1]), 32'h05555555);
        check_eq("load_row27", 32'(pixels[27]), 32'h05555555);
        check_eq("load_ready_low", 32'(pix_ready), 32'd0);
        tick();
        check_eq("stale_guard", 32'(state), 32'd2);
        l1_done = 1'b0; l3_done = 1'b1;
        tick();
        check_eq("l1_low_hold", 32'(state), 32'd2);
        tick();
        check_eq("l3_in_l1", 32'(state), 32'd2);
        l3_done = 1'b0; l1_done = 1'b1;
        tick();
        check_eq("l1_adv", 32'(state), 32'd3);

        // LAYER_2: start, pixels and foreign done flags must be ignored.
        start = 1'b1; pix_valid = 1'b1; pix_data = 1'b1; l3_done = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_eq("l2_hold", 32'(state), 32'd3);
        check_eq("l2_no_clr", 32'(layer_clr), 32'd0);
        check_eq("l2_buf_row0", 32'(pixels[0]), 32'h0AAAAAAA);
        start = 1'b0; pix_valid = 1'b0; pix_data = 1'b0; l1_done = 1'b0;
        l2_done = 1'b1;
        tick();
        check_eq("l2_adv", 32'(state), 32'd4);
        l2_done = 1'b0;
        tick();
        check_eq("l3_stale_guard", 32'(state), 32'd4);
        check_eq("l3_no_fdone", 32'(frame_done), 32'd0);
        tick();
        check_eq("frame_end_state", 32'(state), 32'd0);
        check_eq("frame_done_pulse", 32'(frame_done), 32'd1);
        check_eq("frame_end_busy", 32'(busy), 32'd0);
        l3_done = 1'b0;
        tick();
        check_eq("frame_done_low", 32'(frame_done), 32'd0);
        check_eq("frame_done_count1", 32'(fd_cnt), 32'd1);
        check_eq("frame_err", 32'(err), 32'd0);

        // Reset mid-load after 400 pixels.
        start = 1'b1;
        tick();
        start = 1'b0;
        load_frame(400, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_state", 32'(state), 32'd0);
        check_eq("mid_rst_ready", 32'(pix_ready), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_pix0", 32'(pixels[0]), 32'd0);
        check_eq("mid_rst_pix13", 32'(pixels[13]), 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("no_restart", 32'(state), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        load_frame(784, 1'b1);
        check_eq("reload_state", 32'(state), 32'd2);
        check_eq("reload_row0", 32'(pixels[0]), 32'h05555555);
        check_eq("reload_row1", 32'(pixels[1]), 32'h0AAAAAAA);
        check_eq("reload_row14", 32'(pixels[14]), 32'h05555555);
        check_eq("rst_no_fdone", 32'(fd_cnt), 32'd1);
        tick();
        l1_done = 1'b1;
        tick();
        l1_done = 1'b0;
        check_eq("f2_l2", 32'(state), 32'd3);

`ifdef BNN_SEQ_TIMEOUT_EN
        // l2_done never arrives: watchdog aborts after 16 cycles in LAYER_2.
        n = 1;
        while (state == 3'd3 && n < 40) begin
            tick();
            if (state == 3'd3) n++;
        end
        check_eq("wd_cycles", 32'(n), 32'd16);
        check_eq("wd_state", 32'(state), 32'd0);
        check_eq("wd_err", 32'(err), 32'd1);
        check_eq("wd_no_fdone", 32'(fd_cnt), 32'd1);
        tick();
        check_eq("wd_err_sticky", 32'(err), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("wd_err_clr", 32'(err), 32'd0);
        check_eq("wd_restart", 32'(state), 32'd1);
`else
        n = 0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("l2_waits", 32'(state), 32'd3);
        l2_done = 1'b1;
        tick();
        l2_done = 1'b0;
        tick();
        l3_done = 1'b1;
        tick();
        l3_done = 1'b0;
        check_eq("f2_end_state", 32'(state), 32'd0);
        check_eq("f2_err", 32'(err), 32'd0);
        tick();
        check_eq("f2_fdone_count", 32'(fd_cnt + n), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
